matmul_engine: RTL and testbench
================================

# matmul_engine

Parametrised matrix-product engine: the next generation of the X-buffer / coefficient-ROM / ALU / write-back chain. Computes P = A(M×K) · X(K×NCH) with NCH parallel unsigned MAC lanes. X is streamed in byte-serially, coefficients come from an external synchronous ROM, and results are written one word per cycle to the result SRAM through a ready-gated write port.

## Interface
- XW, 8: X element width (unsigned)
- AW, 7: coefficient width (unsigned)
- K, 4: inner dimension
- NCH, 4: lanes / X columns
- M, 4: A rows
- ACCW, 18: accumulator width; elaboration error unless XW+AW+clog2(K) ≤ ACCW ≤ RAM_DW
- RAM_AW, 8: SRAM address width
- RAM_DW, 32: SRAM data width
- BASE, 0: first result address
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- x_valid  in  1  X byte present
- x_data  in  XW  X element
- x_ready  out  1  engine accepts X; high only in LOAD
- load_done  out  1  one-cycle pulse on acceptance of the last X element
- coef_addr  out  clog2(M·K)  ROM address = m·K+k
- coef_data  in  AW  ROM data, valid one cycle after coef_addr
- ram_we_n  out  1  active-low write strobe
- ram_addr  out  RAM_AW  write address
- ram_wdata  out  RAM_DW  result, zero-extended
- ram_ry  in  1  SRAM ready; a write completes on a clock edge where ram_we_n=0 and ram_ry=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE, LOAD, COMP, WB, DONE.
- IDLE → LOAD on start=1. start in any other state is ignored.
- LOAD: element i (0..K·NCH−1) is accepted when x_valid & x_ready. It is stored as X[i/NCH][i%NCH] (row-major). x_valid outside LOAD is ignored. After the last element: load_done pulse, → COMP with m=0.
- COMP for row m, cycles c=0..K:
  - For c<K: drive coef_addr=m·K+c.
  - For c≥1: every lane n does acc[n] = (c==1 ? 0 : acc[n]) + coef_data·X[c−1][n], mod 2^ACCW.
  - After c=K: → WB.
- WB: writes lane n=0..NCH−1 in order.
  - ram_addr = (BASE + m·NCH + n) mod 2^RAM_AW.
  - ram_wdata = zero-extended acc[n].
  - ram_we_n is held low with addr/data stable until ram_ry=1, then the engine advances to the next lane.
  - After the last lane: m<M−1 → COMP (m+1); otherwise → DONE.
- DONE: done=1 for one cycle, → IDLE. X contents are retained, but a new run always reloads X.

## Timing
- Reset values: x_ready 0, load_done 0, coef_addr 0, ram_we_n 1, ram_addr 0, ram_wdata 0, busy 0, done 0. State is IDLE, m/k/n counters are 0, accumulators are 0.
- Reset mid-operation: the above values apply immediately. Partial X and partial results are discarded and an in-flight write is abandoned. Results already written stay in the SRAM.
- LOAD is entered on the edge after start; x_ready is high from that cycle.
- Per row with ram_ry=1: K+1 COMP cycles plus NCH WB cycles.
- Latency from the last X acceptance edge to done high: M·(K+1+NCH) cycles (36 at defaults), plus one cycle for each cycle ram_ry=0 during WB.
- A row's writes complete strictly before the next row's ROM reads begin.

## Structure
- Package matmul_pkg holds:
  - the state enum;
  - a clog2 helper;
  - derived widths: element count K·NCH, ROM address width, lane/row counter widths.
- Sub-module mac_lane, instantiated NCH times, holds:
  - its X column register (K×XW);
  - the load write-enable per row;
  - the multiply and the ACCW accumulator with clear-on-first.
- The top holds the FSM, counters, ROM addressing and the write port.

## Test plan
1. X elements 1..16; ROM with A[m][k]=1 if m==k else 0 → 16 writes at addresses 0..15, word at address 4m+n = 4m+n+1; done 36 cycles after the last X edge.
2. All X=255, all A=127 → every word 0x0001FA04 (4·255·127); no wrap.
3. ram_ry held low 3 cycles during row 0, lane 1 → ram_addr=1 and its data held stable with ram_we_n=0. No write is skipped or duplicated; done arrives 3 cycles later than in scenario 1.
4. x_valid toggling with random gaps, plus x_valid=1 pulses in IDLE → only the 16 handshaked bytes are stored; load_done pulses once, on the 16th; results match scenario 1.
5. rst asserted during row 1, lane 2 → all outputs take reset values in that same cycle. A following full run yields correct results at all 16 addresses.
6. start pulsed during COMP and WB → no restart, busy stays high, one done pulse; BASE=250 → addresses wrap 250..255, 0..9.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix-product engine.
package matmul_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMP,
    S_WB,
    S_DONE
  } state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int v);
    int r;
    int t;
    r = 0;
    t = v - 1;
    while (t > 0) begin
      r = r + 1;
      t = t >> 1;
    end
    return r;
  endfunction

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Number of X elements streamed per run.
  function automatic int elem_cnt(input int k, input int nch);
    return k * nch;
  endfunction

  // Coefficient ROM address width (M*K words).
  function automatic int rom_aw(input int m, input int k);
    return cnt_w(m * k);
  endfunction

endpackage

// File: rtl/matmul_engine_mac_lane.sv
// One MAC lane: holds an X column and accumulates coef * X[row] for one output column.
module mac_lane
  import matmul_pkg::*;
#(
  parameter int XW   = 8,
  parameter int AW   = 7,
  parameter int K    = 4,
  parameter int ACCW = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [cnt_w(K)-1:0]   wr_row_i,
  input  logic [XW-1:0]         x_data_i,
  input  logic                  mac_en_i,
  input  logic                  first_i,
  input  logic [cnt_w(K)-1:0]   rd_row_i,
  input  logic [AW-1:0]         coef_i,
  output logic [ACCW-1:0]       acc_o
);

  localparam int RW = cnt_w(K);
  localparam int PW = XW + AW;

  logic [K-1:0][XW-1:0] x_q;
  logic [K-1:0]         row_we;
  logic [XW-1:0]        x_sel;
  logic [PW-1:0]        prod;
  logic [ACCW-1:0]      acc_q, acc_d;

  // Decode the load row into one write enable per column register row.
  always_comb begin
    row_we = '0;
    for (int r = 0; r < K; r++)
      row_we[r] = wr_en_i && (wr_row_i == RW'(r));
  end

  // X column storage, written one element per accepted byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) x_q <= '0;
    else begin
      for (int r = 0; r < K; r++)
        if (row_we[r]) x_q[r] <= x_data_i;
    end
  end

  assign x_sel = x_q[rd_row_i];
  assign prod  = PW'(coef_i) * PW'(x_sel);

  // First product of a row replaces the accumulator instead of adding to it.
  always_comb begin
    acc_d = acc_q;
    if (mac_en_i) acc_d = (first_i ? '0 : acc_q) + ACCW'(prod);
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matmul_engine.sv
// Matrix-product engine top: FSM, X load, ROM addressing, lane array and SRAM write port.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int XW     = 8,
  parameter int AW     = 7,
  parameter int K      = 4,
  parameter int NCH    = 4,
  parameter int M      = 4,
  parameter int ACCW   = 18,
  parameter int RAM_AW = 8,
  parameter int RAM_DW = 32,
  parameter int BASE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    x_valid,
  input  logic [XW-1:0]           x_data,
  output logic                    x_ready,
  output logic                    load_done,
  output logic [rom_aw(M,K)-1:0]  coef_addr,
  input  logic [AW-1:0]           coef_data,
  output logic                    ram_we_n,
  output logic [RAM_AW-1:0]       ram_addr,
  output logic [RAM_DW-1:0]       ram_wdata,
  input  logic                    ram_ry,
  output logic                    busy,
  output logic                    done
);

  localparam int NEL = elem_cnt(K, NCH);
  localparam int CAW = rom_aw(M, K);
  localparam int ECW = cnt_w(NEL);
  localparam int KCW = cnt_w(K + 1);
  localparam int RW  = cnt_w(K);
  localparam int NCW = cnt_w(NCH);
  localparam int MCW = cnt_w(M);

  localparam logic [ECW-1:0] E_LAST = ECW'(NEL - 1);
  localparam logic [KCW-1:0] C_LAST = KCW'(K);
  localparam logic [KCW-1:0] C_ADDR = KCW'(K - 1);
  localparam logic [NCW-1:0] N_LAST = NCW'(NCH - 1);
  localparam logic [MCW-1:0] M_LAST = MCW'(M - 1);

  if ((XW + AW + clog2(K) > ACCW) || (ACCW > RAM_DW)) begin : g_bad_accw
    $error("matmul_engine: ACCW must satisfy XW+AW+clog2(K) <= ACCW <= RAM_DW");
  end

  state_e             state_q;
  logic [ECW-1:0]     i_q;
  logic [RW-1:0]      xr_q;
  logic [NCW-1:0]     xc_q;
  logic [KCW-1:0]     c_q;
  logic [NCW-1:0]     n_q;
  logic [MCW-1:0]     m_q;
  logic               x_ready_q, load_done_q, we_n_q, busy_q, done_q;
  logic [CAW-1:0]     coef_addr_q;
  logic [RAM_AW-1:0]  ram_addr_q;
  logic [NCH-1:0][ACCW-1:0] acc_all;

  logic mac_en, first;
  logic [RW-1:0] rd_row;

  assign mac_en = (state_q == S_COMP) && (c_q != '0);
  assign first  = (c_q == KCW'(1));
  assign rd_row = RW'(c_q - 1'b1);

  for (genvar n = 0; n < NCH; n++) begin : g_lane
    mac_lane #(.XW(XW), .AW(AW), .K(K), .ACCW(ACCW)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  ((state_q == S_LOAD) && x_valid && (xc_q == NCW'(n))),
      .wr_row_i (xr_q),
      .x_data_i (x_data),
      .mac_en_i (mac_en),
      .first_i  (first),
      .rd_row_i (rd_row),
      .coef_i   (coef_data),
      .acc_o    (acc_all[n])
    );
  end

  // Control FSM with all handshake/port outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      xr_q        <= '0;
      xc_q        <= '0;
      c_q         <= '0;
      n_q         <= '0;
      m_q         <= '0;
      x_ready_q   <= 1'b0;
      load_done_q <= 1'b0;
      we_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      coef_addr_q <= '0;
      ram_addr_q  <= '0;
    end else begin
      load_done_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q   <= S_LOAD;
          x_ready_q <= 1'b1;
          busy_q    <= 1'b1;
          i_q       <= '0;
          xr_q      <= '0;
          xc_q      <= '0;
        end
        S_LOAD: if (x_valid) begin
          i_q <= i_q + 1'b1;
          if (xc_q == N_LAST) begin
            xc_q <= '0;
            xr_q <= xr_q + 1'b1;
          end else begin
            xc_q <= xc_q + 1'b1;
          end
          if (i_q == E_LAST) begin
            state_q     <= S_COMP;
            x_ready_q   <= 1'b0;
            load_done_q <= 1'b1;
            m_q         <= '0;
            c_q         <= '0;
            coef_addr_q <= '0;
          end
        end
        S_COMP: begin
          // ROM address leads the MAC by one cycle to cover the ROM latency.
          if (c_q < C_ADDR) coef_addr_q <= coef_addr_q + 1'b1;
          if (c_q == C_LAST) begin
            state_q    <= S_WB;
            n_q        <= '0;
            we_n_q     <= 1'b0;
            ram_addr_q <= RAM_AW'(BASE) + RAM_AW'(m_q) * RAM_AW'(NCH);
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        S_WB: if (ram_ry) begin
          if (n_q == N_LAST) begin
            we_n_q <= 1'b1;
            if (m_q == M_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_COMP;
              m_q         <= m_q + 1'b1;
              c_q         <= '0;
              coef_addr_q <= coef_addr_q + 1'b1;
            end
          end else begin
            n_q        <= n_q + 1'b1;
            ram_addr_q <= ram_addr_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x_ready   = x_ready_q;
  assign load_done = load_done_q;
  assign coef_addr = coef_addr_q;
  assign ram_we_n  = we_n_q;
  assign ram_addr  = ram_addr_q;
  // Accumulators are registers and stay frozen through WB, so the mux output is stable.
  assign ram_wdata = RAM_DW'(acc_all[n_q]);
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Scoreboard bench for matmul_engine (BASE=0 instance plus a BASE=250 instance for wrap).
module tb_matmul_engine;

  logic       clk = 1'b0;
  logic       rst, start, x_valid, ram_ry;
  logic [7:0] x_data;

  logic       x_ready, load_done, ram_we_n, busy, done;
  logic [3:0] coef_addr;
  logic [6:0] coef_data;
  logic [7:0] ram_addr;
  logic [31:0] ram_wdata;

  logic       x_ready_b, load_done_b, ram_we_n_b, busy_b, done_b;
  logic [3:0] coef_addr_b;
  logic [6:0] coef_data_b;
  logic [7:0] ram_addr_b;
  logic [31:0] ram_wdata_b;

  always #5 clk = ~clk;

  matmul_engine u_dut (
    .clk(clk), .rst(rst), .start(start), .x_valid(x_valid), .x_data(x_data),
    .x_ready(x_ready), .load_done(load_done), .coef_addr(coef_addr), .coef_data(coef_data),
    .ram_we_n(ram_we_n), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ry(ram_ry),
    .busy(busy), .done(done)
  );

  matmul_engine #(.BASE(250)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .x_valid(x_valid), .x_data(x_data),
    .x_ready(x_ready_b), .load_done(load_done_b), .coef_addr(coef_addr_b), .coef_data(coef_data_b),
    .ram_we_n(ram_we_n_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_ry(ram_ry),
    .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic [6:0]  rom [16];
  logic [7:0]  xs  [16];
  logic [31:0] mem [256];
  wr_t exp_q[$];

  int n_chk = 0, n_err = 0;
  int cyc = 0, ld_cnt = 0, done_cnt = 0, t_last = 0, t_done = 0, b_cnt = 0;
  bit stall_req = 0, stalled = 0;

  // Synchronous ROM models: data one cycle after address.
  always_ff @(posedge clk) begin
    coef_data   <= rom[coef_addr];
    coef_data_b <= rom[coef_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: a write completes on the next edge when we_n=0 and ry=1.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (load_done) begin ld_cnt++; t_last = cyc; end
      if (done)      begin done_cnt++; t_done = cyc; end
      if (!ram_we_n && ram_ry) begin
        if (exp_q.size() == 0) chk("unexpected_write", {24'd0, ram_addr}, 32'hFFFF_FFFF);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", {24'd0, ram_addr}, {24'd0, e.addr});
          chk("wr_data", ram_wdata, e.data);
        end
        mem[ram_addr] = ram_wdata;
      end
      if (!ram_we_n_b && ram_ry) begin
        logic [7:0] ea;
        ea = 8'(250 + b_cnt);
        chk("b_wrap_addr", {24'd0, ram_addr_b}, {24'd0, ea});
        b_cnt++;
      end
    end
  end

  // Stall injector: ram_ry low for 3 cycles while row 0 lane 1 is on the port.
  initial forever begin
    @(posedge clk); #1;
    if (stall_req && !stalled && !ram_we_n && ram_addr == 8'd1) begin
      stalled = 1;
      ram_ry  = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("stall_addr", {24'd0, ram_addr}, 32'd1);
        chk("stall_we_n", {31'd0, ram_we_n}, 32'd0);
        chk("stall_data", ram_wdata, 32'd2);
      end
      @(posedge clk); #1;
      ram_ry = 1'b1;
    end
  end

  task automatic push_expected();
    for (int m = 0; m < 4; m++)
      for (int n = 0; n < 4; n++) begin
        int s;
        wr_t e;
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(rom[m*4+k]) * int'(xs[k*4+n]);
        e.addr = 8'(m*4 + n);
        e.data = 32'(s % (1 << 18));
        exp_q.push_back(e);
      end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"},   {27'd0, x_ready, load_done, ram_we_n, busy, done}, 32'b00100);
    chk({tag, "_coef"},  {28'd0, coef_addr}, 32'd0);
    chk({tag, "_addr"},  {24'd0, ram_addr}, 32'd0);
    chk({tag, "_wdata"}, ram_wdata, 32'd0);
  endtask

  task automatic feed_x(input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        x_valid = 1'b0;
        x_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      x_valid = 1'b1;
      x_data  = xs[i];
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
  endtask

  task automatic run(input bit gaps, input bit idle_junk, input bit start_mid,
                     input bit stall, input int exp_lat, input bit do_rst);
    int ld0, d0, t;
    push_expected();
    ld0 = ld_cnt;
    d0  = done_cnt;
    b_cnt = 0;
    stall_req = stall;
    stalled   = 0;
    if (idle_junk) begin
      x_valid = 1'b1;
      x_data  = 8'hAA;
      repeat (3) begin
        @(posedge clk); #1;
        chk("idle_x_ready", {31'd0, x_ready}, 32'd0);
      end
      x_valid = 1'b0;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("load_x_ready", {31'd0, x_ready}, 32'd1);
    chk("load_busy", {31'd0, busy}, 32'd1);
    feed_x(gaps);
    if (do_rst) begin
      t = 0;
      while (!(!ram_we_n && ram_addr == 8'd6) && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 200) chk("rst_wait_timeout", 32'd0, 32'd1);
      chk("rst_ld_pulses", 32'(ld_cnt - ld0), 32'd1);
      rst = 1'b1;
      #1;
      check_reset_outs("midrst");
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    t = 0;
    while (done_cnt == d0 && t < 400) begin
      @(posedge clk); #1;
      t++;
      start = start_mid && (t == 3 || t == 8);
      if (start_mid && (t == 4 || t == 9)) chk("mid_busy", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    if (t >= 400) chk("done_timeout", 32'd0, 32'd1);
    chk("latency", 32'(t_done - t_last), 32'(exp_lat));
    repeat (3) begin @(posedge clk); #1; end
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("load_done_pulses", 32'(ld_cnt - ld0), 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("writes_left", 32'(exp_q.size()), 32'd0);
    chk("b_write_count", 32'(b_cnt), 32'd16);
  endtask

  task automatic setup_identity();
    for (int i = 0; i < 16; i++) begin
      xs[i]  = 8'(i + 1);
      rom[i] = ((i / 4) == (i % 4)) ? 7'd1 : 7'd0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x_valid = 1'b0; x_data = '0; ram_ry = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    setup_identity();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: identity A, X = 1..16
    run(0, 0, 0, 0, 36, 0);
    for (int a = 0; a < 16; a++) chk("s1_mem", mem[a], 32'(a + 1));

    // 2: maximum operands, no wrap
    for (int i = 0; i < 16; i++) begin xs[i] = 8'd255; rom[i] = 7'd127; end
    run(0, 0, 0, 0, 36, 0);
    chk("s2_word5", mem[5], 32'h0001FA04);
    chk("s2_word15", mem[15], 32'h0001FA04);

    // 3: ram_ry stall on row 0 lane 1
    setup_identity();
    run(0, 0, 0, 1, 39, 0);

    // 4: gapped X stream plus x_valid junk in IDLE
    run(1, 1, 0, 0, 36, 0);
    for (int a = 0; a < 16; a++) chk("s4_mem", mem[a], 32'(a + 1));

    // 5: reset during row 1 lane 2, then a full run with random data
    run(0, 0, 0, 0, 36, 1);
    for (int i = 0; i < 16; i++) begin
      xs[i]  = 8'($urandom);
      rom[i] = 7'($urandom);
    end
    run(1, 0, 0, 0, 36, 0);

    // 6: start pulses mid-run are ignored
    setup_identity();
    run(0, 0, 1, 0, 36, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
